// File: rtl/cpu6_csr_exu_pkg.sv
// cpu6_csr_exu_pkg: shared widths, funct3 low-bit encodings and FSM states for the CSR execution unit
package cpu6_csr_exu_pkg;
  localparam int CPU6_XLEN = 32;
  localparam int CPU6_CSR_SIZE = 12;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_WB = 3'd3;
  localparam logic [2:0] S_ILL = 3'd4;
  // funct3 bit 2 only selects the immediate form, so 000 and 100 are the illegal codes
  function automatic logic is_illegal(input logic [2:0] op);
    return op[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/cpu6_csr_exu.sv
// cpu6_csr_exu: Zicsr read-modify-write sequencer driving the CSR file access port
module cpu6_csr_exu
  import cpu6_csr_exu_pkg::*;
#(
  parameter int XLEN = CPU6_XLEN,
  parameter int CSR_SIZE = CPU6_CSR_SIZE
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [2:0]          i_req_op,
  input  logic [CSR_SIZE-1:0] i_req_idx,
  input  logic [4:0]          i_req_rs1_idx,
  input  logic [XLEN-1:0]     i_req_rs1_dat,
  input  logic [4:0]          i_req_rd_idx,
  input  logic                i_flush,
  output logic                o_csr_rd_en,
  output logic                o_csr_wr_en,
  output logic [CSR_SIZE-1:0] o_csr_idx,
  output logic [XLEN-1:0]     o_csr_write_dat,
  input  logic [XLEN-1:0]     i_csr_read_dat,
  output logic                o_wb_valid,
  output logic [4:0]          o_wb_rd_idx,
  output logic [XLEN-1:0]     o_wb_dat,
  input  logic                i_wb_ready,
  output logic                o_illegal_op
);
  logic [2:0]          r_state, w_next;
  logic [2:0]          r_op;
  logic [CSR_SIZE-1:0] r_idx;
  logic [4:0]          r_rd, r_rs1;
  logic [XLEN-1:0]     r_opnd, r_old, w_new;
  logic                w_accept, w_rd_sup, w_wr_sup;

  assign w_accept = r_state == S_IDLE && i_req_valid && !i_flush;
  // RW with rd=x0 must not read; RS/RC with rs1=x0 must not write
  assign w_rd_sup = r_op[1:0] == OP_RW && r_rd == 5'd0;
  assign w_wr_sup = r_op[1:0] != OP_RW && r_rs1 == 5'd0;

  always_comb begin
    w_new = r_op[1:0] == OP_RS ? (r_old | r_opnd) : r_op[1:0] == OP_RC ? (r_old & ~r_opnd) : r_opnd;
    w_next = i_flush ? S_IDLE :
             r_state == S_IDLE  ? (w_accept ? (is_illegal(i_req_op) ? S_ILL : S_READ) : S_IDLE) :
             r_state == S_READ  ? S_WRITE :
             r_state == S_WRITE ? (r_rd != 5'd0 ? S_WB : S_IDLE) :
             r_state == S_WB    ? (i_wb_ready ? S_IDLE : S_WB) : S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_idx   <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_opnd  <= '0;
      r_old   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= i_req_op;
        r_idx  <= i_req_idx;
        r_rd   <= i_req_rd_idx;
        r_rs1  <= i_req_rs1_idx;
        r_opnd <= i_req_op[2] ? {{(XLEN-5){1'b0}}, i_req_rs1_idx} : i_req_rs1_dat;
      end
      if (r_state == S_READ) r_old <= w_rd_sup ? '0 : i_csr_read_dat;
    end
  end

  assign o_req_ready     = r_state == S_IDLE;
  assign o_csr_idx       = (r_state == S_READ || r_state == S_WRITE) ? r_idx : '0;
  assign o_csr_rd_en     = r_state == S_READ && !w_rd_sup && !i_flush;
  assign o_csr_wr_en     = r_state == S_WRITE && !w_wr_sup && !i_flush;
  assign o_csr_write_dat = r_state == S_WRITE ? w_new : '0;
  assign o_wb_valid      = r_state == S_WB && !i_flush;
  assign o_wb_rd_idx     = r_state == S_WB ? r_rd : '0;
  assign o_wb_dat        = r_state == S_WB ? r_old : '0;
  assign o_illegal_op    = r_state == S_ILL;
endmodule

// File: tb/tb_cpu6_csr_exu.sv
// tb_cpu6_csr_exu: directed checks of the CSR execution unit against a small CSR file model
module tb_cpu6_csr_exu;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_ready;
  logic [2:0]  req_op = 0;
  logic [11:0] req_idx = 0;
  logic [4:0]  req_rs1_idx = 0, req_rd_idx = 0;
  logic [31:0] req_rs1_dat = 0;
  logic        flush = 0, csr_rd_en, csr_wr_en, wb_valid, wb_ready = 1, illegal_op;
  logic [11:0] csr_idx;
  logic [31:0] csr_write_dat, csr_read_dat, wb_dat;
  logic [4:0]  wb_rd_idx;
  logic [31:0] mem [0:4095];
  logic        poke_en = 0;
  logic [11:0] poke_idx = 0;
  logic [31:0] poke_dat = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cpu6_csr_exu dut (
    .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_idx(req_idx), .i_req_rs1_idx(req_rs1_idx),
    .i_req_rs1_dat(req_rs1_dat), .i_req_rd_idx(req_rd_idx), .i_flush(flush),
    .o_csr_rd_en(csr_rd_en), .o_csr_wr_en(csr_wr_en), .o_csr_idx(csr_idx),
    .o_csr_write_dat(csr_write_dat), .i_csr_read_dat(csr_read_dat),
    .o_wb_valid(wb_valid), .o_wb_rd_idx(wb_rd_idx), .o_wb_dat(wb_dat),
    .i_wb_ready(wb_ready), .o_illegal_op(illegal_op)
  );

  assign csr_read_dat = mem[csr_idx];
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_dat;
    else if (csr_wr_en) mem[csr_idx] <= csr_write_dat;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] idx, input logic [31:0] dat);
    poke_en = 1; poke_idx = idx; poke_dat = dat;
    step();
    poke_en = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [11:0] idx, input logic [4:0] rs1, input logic [31:0] dat, input logic [4:0] rd);
    req_op = op; req_idx = idx; req_rs1_idx = rs1; req_rs1_dat = dat; req_rd_idx = rd; req_valid = 1;
    step();
    req_valid = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    step(); step();
    checks++;
    if ({req_ready, csr_rd_en, csr_wr_en, wb_valid, illegal_op} !== 5'b10000 || csr_idx !== 0 || csr_write_dat !== 0 || wb_dat !== 0 || wb_rd_idx !== 0) begin
      errors++; $display("FAIL reset_outputs: got ready/rd/wr/wbv/ill=%b%b%b%b%b idx=%h wdat=%h wb=%h rd=%0d want 10000 and zeros",
        req_ready, csr_rd_en, csr_wr_en, wb_valid, illegal_op, csr_idx, csr_write_dat, wb_dat, wb_rd_idx);
    end
    reset = 0;
  endtask

  task automatic test_rw;
    poke(12'h341, 32'h100);
    issue(3'b001, 12'h341, 5'd7, 32'h200, 5'd5);
    checks++;
    if (csr_rd_en !== 1 || csr_wr_en !== 0 || csr_idx !== 12'h341) begin
      errors++; $display("FAIL rw_read: rd_en=%b wr_en=%b idx=%h want 1 0 341", csr_rd_en, csr_wr_en, csr_idx);
    end
    step();
    checks++;
    if (csr_wr_en !== 1 || csr_rd_en !== 0 || csr_write_dat !== 32'h200 || csr_idx !== 12'h341) begin
      errors++; $display("FAIL rw_write: wr_en=%b rd_en=%b dat=%h idx=%h want 1 0 200 341", csr_wr_en, csr_rd_en, csr_write_dat, csr_idx);
    end
    step();
    checks++;
    if (wb_valid !== 1 || wb_dat !== 32'h100 || wb_rd_idx !== 5'd5 || csr_idx !== 0) begin
      errors++; $display("FAIL rw_wb: valid=%b dat=%h rd=%0d idx=%h want 1 100 5 000", wb_valid, wb_dat, wb_rd_idx, csr_idx);
    end
    step();
    checks++;
    if (req_ready !== 1 || wb_valid !== 0 || mem[12'h341] !== 32'h200) begin
      errors++; $display("FAIL rw_done: ready=%b wbv=%b csr=%h want 1 0 200", req_ready, wb_valid, mem[12'h341]);
    end
  endtask

  task automatic test_set_clear;
    logic wr_seen;
    poke(12'h341, 32'h100);
    issue(3'b010, 12'h341, 5'd0, 32'h0, 5'd3);
    wr_seen = csr_wr_en;
    step(); wr_seen |= csr_wr_en;
    step(); wr_seen |= csr_wr_en;
    checks++;
    if (wr_seen !== 0 || wb_valid !== 1 || wb_dat !== 32'h100 || wb_rd_idx !== 5'd3) begin
      errors++; $display("FAIL rs_x0: wr_seen=%b wbv=%b dat=%h rd=%0d want 0 1 100 3", wr_seen, wb_valid, wb_dat, wb_rd_idx);
    end
    step();
    poke(12'h300, 32'h10C);
    issue(3'b111, 12'h300, 5'd4, 32'hFFFF_FFFF, 5'd2);
    step();
    checks++;
    if (csr_wr_en !== 1 || csr_write_dat !== 32'h108) begin
      errors++; $display("FAIL rci_write: wr_en=%b dat=%h want 1 108", csr_wr_en, csr_write_dat);
    end
    step();
    checks++;
    if (wb_dat !== 32'h10C || mem[12'h300] !== 32'h108) begin
      errors++; $display("FAIL rci_wb: wb=%h csr=%h want 10c 108", wb_dat, mem[12'h300]);
    end
    step();
    issue(3'b110, 12'h300, 5'd3, 32'h0, 5'd4);
    step();
    checks++;
    if (csr_wr_en !== 1 || csr_write_dat !== 32'h10B) begin
      errors++; $display("FAIL rsi_write: wr_en=%b dat=%h want 1 10b", csr_wr_en, csr_write_dat);
    end
    step(); step();
  endtask

  task automatic test_rw_rd0;
    poke(12'h340, 32'h55);
    issue(3'b001, 12'h340, 5'd9, 32'h44, 5'd0);
    checks++;
    if (csr_rd_en !== 0) begin
      errors++; $display("FAIL rw_rd0_read: rd_en=%b want 0", csr_rd_en);
    end
    step();
    checks++;
    if (csr_wr_en !== 1 || csr_write_dat !== 32'h44) begin
      errors++; $display("FAIL rw_rd0_write: wr_en=%b dat=%h want 1 44", csr_wr_en, csr_write_dat);
    end
    step();
    checks++;
    if (req_ready !== 1 || wb_valid !== 0 || mem[12'h340] !== 32'h44) begin
      errors++; $display("FAIL rw_rd0_done: ready=%b wbv=%b csr=%h want 1 0 44", req_ready, wb_valid, mem[12'h340]);
    end
  endtask

  task automatic test_illegal;
    issue(3'b100, 12'h341, 5'd1, 32'h1, 5'd1);
    checks++;
    if (illegal_op !== 1 || csr_rd_en !== 0 || csr_wr_en !== 0 || req_ready !== 0) begin
      errors++; $display("FAIL ill_pulse: ill=%b rd=%b wr=%b ready=%b want 1 0 0 0", illegal_op, csr_rd_en, csr_wr_en, req_ready);
    end
    step();
    checks++;
    if (illegal_op !== 0 || req_ready !== 1 || csr_wr_en !== 0) begin
      errors++; $display("FAIL ill_end: ill=%b ready=%b wr=%b want 0 1 0", illegal_op, req_ready, csr_wr_en);
    end
    issue(3'b000, 12'h341, 5'd1, 32'h1, 5'd1);
    checks++;
    if (illegal_op !== 1 || csr_rd_en !== 0) begin
      errors++; $display("FAIL ill_000: ill=%b rd=%b want 1 0", illegal_op, csr_rd_en);
    end
    step();
  endtask

  task automatic test_flush;
    poke(12'h305, 32'h77);
    issue(3'b001, 12'h305, 5'd2, 32'hAA, 5'd1);
    step();
    flush = 1;
    #1;
    checks++;
    if (csr_wr_en !== 0) begin
      errors++; $display("FAIL flush_write: wr_en=%b want 0", csr_wr_en);
    end
    step();
    flush = 0;
    checks++;
    if (req_ready !== 1 || wb_valid !== 0 || mem[12'h305] !== 32'h77) begin
      errors++; $display("FAIL flush_idle: ready=%b wbv=%b csr=%h want 1 0 77", req_ready, wb_valid, mem[12'h305]);
    end
    flush = 1;
    issue(3'b001, 12'h305, 5'd2, 32'hAA, 5'd1);
    flush = 0;
    checks++;
    if (req_ready !== 1 || csr_rd_en !== 0 || csr_idx !== 0) begin
      errors++; $display("FAIL flush_accept: ready=%b rd=%b idx=%h want 1 0 000", req_ready, csr_rd_en, csr_idx);
    end
  endtask

  task automatic test_reset_wb;
    issue(3'b001, 12'h341, 5'd1, 32'h5, 5'd6);
    wb_ready = 0;
    step(); step();
    reset = 1;
    step();
    reset = 0;
    wb_ready = 1;
    checks++;
    if ({req_ready, csr_rd_en, csr_wr_en, wb_valid, illegal_op} !== 5'b10000 || wb_dat !== 0 || wb_rd_idx !== 0 || csr_idx !== 0) begin
      errors++; $display("FAIL reset_wb: ready/rd/wr/wbv/ill=%b%b%b%b%b wb=%h rd=%0d want 10000 0 0",
        req_ready, csr_rd_en, csr_wr_en, wb_valid, illegal_op, wb_dat, wb_rd_idx);
    end
  endtask

  task automatic test_backpressure;
    poke(12'h341, 32'h200);
    wb_ready = 0;
    issue(3'b010, 12'h341, 5'd1, 32'h0F0, 5'd9);
    step(); step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wb_valid !== 1 || wb_dat !== 32'h200 || wb_rd_idx !== 5'd9 || req_ready !== 0) begin
        errors++; $display("FAIL bp_hold%0d: valid=%b dat=%h rd=%0d ready=%b want 1 200 9 0", i, wb_valid, wb_dat, wb_rd_idx, req_ready);
      end
      step();
    end
    wb_ready = 1;
    step();
    checks++;
    if (req_ready !== 1 || wb_valid !== 0 || mem[12'h341] !== 32'h2F0) begin
      errors++; $display("FAIL bp_release: ready=%b wbv=%b csr=%h want 1 0 2f0", req_ready, wb_valid, mem[12'h341]);
    end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_set_clear();
    test_rw_rd0();
    test_illegal();
    test_flush();
    test_reset_wb();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
